uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16: clk cycles per bit period; even, at least 8.
REQ-002 The block SHALL have port clk, input, 1: single clock at OVERSAMPLE x baud rate.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port rx_i, input, 1: serial line, idle high, asynchronous to clk.
REQ-005 The block SHALL have port parity_i, input, 2: 00 none, 01 odd, 10 even, 11 treated as none.
REQ-006 The block SHALL have port data_o, output, 8: last received byte.
REQ-007 The block SHALL have port valid_o, output, 1: single-cycle pulse, frame complete.
REQ-008 The block SHALL have port parity_err_o, output, 1: parity mismatch for the frame flagged by valid_o.
REQ-009 The block SHALL have port frame_err_o, output, 1: stop bit sampled 0 for the frame flagged by valid_o.
REQ-010 The block SHALL have port busy_o, output, 1: high in every state except IDLE.

Function
REQ-011 The frame format SHALL be: start bit 0, 8 data bits LSB first, optional parity bit, one stop bit 1.
REQ-012 rx_i SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized signal rxs.
REQ-013 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP.
REQ-014 IDLE->START SHALL occur on a 1->0 transition of rxs; parity_i SHALL be latched at that edge and ignored for the rest of the frame.
REQ-015 START SHALL sample rxs OVERSAMPLE/2 cycles after the edge: 0 -> DATA, 1 -> IDLE (glitch rejected, no valid_o).
REQ-016 DATA, PARITY and STOP SHALL each sample rxs once, OVERSAMPLE cycles after the previous sample (bit centre).
REQ-017 DATA SHALL shift in 8 bits (3-bit index, no wrap past 7), then go to PARITY if latched parity is 01/10, else STOP.
REQ-018 Parity check: odd requires an odd count of ones over data+parity; even requires an even count; none forces parity_err_o=0.
REQ-019 After the STOP sample the FSM SHALL return to IDLE and, on the next cycle, SHALL update data_o, parity_err_o and frame_err_o and pulse valid_o for exactly 1 cycle.
REQ-020 valid_o SHALL pulse even when parity or frame errors occur; the error flags SHALL hold until the next valid_o.
REQ-021 A line held low (break) SHALL yield one frame with data_o=00 and frame_err_o=1, then SHALL NOT retrigger until rxs returns high and falls again.
REQ-022 Back-to-back frames SHALL be received with no idle time beyond the stop bit, because IDLE is reached at the stop-bit centre.
REQ-023 Latency SHALL be the stop-bit centre plus 1 cycle, plus 2 synchronizer cycles from rx_i.

Reset
REQ-024 While rst=0: FSM in IDLE, counters 0, synchronizer flops 1, data_o=00, valid_o=0, parity_err_o=0, frame_err_o=0, busy_o=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no valid_o; after release the block SHALL wait for a fresh falling edge.

Structure
REQ-026 Shared package uart_pkg SHALL hold the parity encodings (PARITY_NONE/ODD/EVEN) and the rx state enum, shared with uart_tx.
REQ-027 The 2-flop synchronizer SHALL be one sub-module, uart_sync, with reset value 1.

Verification
REQ-028 Send 8'hA5, parity 00 -> one valid_o pulse, data_o=A5, both error flags 0, busy_o low after the pulse.
REQ-029 Send 8'h55 with odd parity and parity bit 1 -> data_o=55, parity_err_o=0; repeat with parity bit 0 -> parity_err_o=1.
REQ-030 Send 8'h3C, even parity, stop bit forced 0 -> data_o=3C, frame_err_o=1; then a line-low break -> one frame_err_o frame only.
REQ-031 Drive a low glitch on rx_i of OVERSAMPLE/4 cycles -> no valid_o pulse, FSM back in IDLE.
REQ-032 Send 8'h01, 8'hFF, 8'h80 back-to-back -> three valid_o pulses with those values in order; also pull rst low in DATA -> no valid_o and all outputs 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings and receiver state codes.
// Also used by uart_tx so both ends agree on the parity_i encoding.
package uart_pkg;

   localparam logic [1:0] PARITY_NONE = 2'b00;
   localparam logic [1:0] PARITY_ODD  = 2'b01;
   localparam logic [1:0] PARITY_EVEN = 2'b10;

   typedef logic [2:0] rx_state_t;

   localparam rx_state_t RX_IDLE   = 3'd0;
   localparam rx_state_t RX_START  = 3'd1;
   localparam rx_state_t RX_DATA   = 3'd2;
   localparam rx_state_t RX_PARITY = 3'd3;
   localparam rx_state_t RX_STOP   = 3'd4;

   // 2'b11 is deliberately folded into "no parity bit on the wire"
   function automatic logic parity_used(input logic [1:0] mode);
      return (mode == PARITY_ODD) || (mode == PARITY_EVEN);
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so a released reset looks like an idle line.
module uart_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], d};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= 2'b11;
      else      sync_q <= sync_d;
   end

   assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8 data bits LSB first, optional odd/even parity,
// one stop bit. Results are registered the cycle after the stop-bit centre.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   input  logic [1:0] parity_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);

   logic rxs;
   logic rxs_prev_q, rxs_prev_d;

   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [1:0]    par_q, par_d;
   logic          perr_q, perr_d;

   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       perr_o_q, perr_o_d;
   logic       ferr_q, ferr_d;

   logic tick;

   uart_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_i),
      .q   (rxs)
   );

   // Start phase samples at half a bit, later phases at full bit periods
   assign tick = (state_q == RX_START) ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);

   always_comb begin
      rxs_prev_d = rxs;
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      par_d      = par_q;
      perr_d     = perr_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      perr_o_d   = perr_o_q;
      ferr_d     = ferr_q;

      if (state_q != RX_IDLE) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end

      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            // Only a real 1->0 transition starts a frame, so a held-low line cannot retrigger
            if (rxs_prev_q && !rxs) begin
               state_d = RX_START;
               par_d   = parity_i;
               perr_d  = 1'b0;
            end
         end
         RX_START: begin
            if (tick) state_d = rxs ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (tick) begin
               shift_d = {rxs, shift_q[7:1]};
               if (idx_q == 3'd7) state_d = parity_used(par_q) ? RX_PARITY : RX_STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         RX_PARITY: begin
            if (tick) begin
               // Odd mode wants an odd ones count over data plus parity bit
               perr_d  = (^shift_q) ^ rxs ^ (par_q == PARITY_ODD);
               state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (tick) begin
               state_d  = RX_IDLE;
               valid_d  = 1'b1;
               data_d   = shift_q;
               perr_o_d = parity_used(par_q) & perr_q;
               ferr_d   = ~rxs;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxs_prev_q <= 1'b1;
         state_q    <= RX_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         par_q      <= PARITY_NONE;
         perr_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_o_q   <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         rxs_prev_q <= rxs_prev_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         perr_q     <= perr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_o_q   <= perr_o_d;
         ferr_q     <= ferr_d;
      end
   end

   assign data_o       = data_q;
   assign valid_o      = valid_q;
   assign parity_err_o = perr_o_q;
   assign frame_err_o  = ferr_q;
   assign busy_o       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected results,
// a monitor pops and compares on every valid_o pulse.
module tb_uart_rx;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_i = 1'b1;
   logic [1:0] parity_i = 2'b00;
   logic [7:0] data_o;
   logic       valid_o, parity_err_o, frame_err_o, busy_o;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   pulses = 0;

   uart_rx #(.OVERSAMPLE(OS)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (rx_i),
      .parity_i     (parity_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .parity_err_o (parity_err_o),
      .frame_err_o  (frame_err_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic bitp(input logic b);
      rx_i = b;
      repeat (OS) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic [1:0] par, input logic pb,
                       input logic stop_bit, input logic epe, input logic efe);
      sb.push_back(exp_t'{d, epe, efe});
      parity_i = par;
      bitp(1'b0);
      for (int i = 0; i < 8; i++) bitp(d[i]);
      if (par == 2'b01 || par == 2'b10) bitp(pb);
      bitp(stop_bit);
      rx_i = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst && valid_o) begin
         pulses++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got data %0h expected no frame", data_o);
         end else begin
            mon_e = sb.pop_front();
            chk("data_o", data_o, mon_e.d);
            chk("parity_err_o", parity_err_o, mon_e.pe);
            chk("frame_err_o", frame_err_o, mon_e.fe);
         end
      end
   end

   initial begin
      int p0;
      int waited;

      repeat (3) @(negedge clk);
      chk("rst_data", data_o, 8'h00);
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_perr", parity_err_o, 1'b0);
      chk("rst_ferr", frame_err_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      rst = 1'b1;
      repeat (2 * OS) @(negedge clk);

      send(8'hA5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2 * OS) @(negedge clk);
      chk("busy_after_a5", busy_o, 1'b0);

      // 0x55 has four ones: odd parity needs parity bit 1
      send(8'h55, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2 * OS) @(negedge clk);
      send(8'h55, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (2 * OS) @(negedge clk);

      // 0x3C has four ones: even parity bit 0, stop forced low
      send(8'h3C, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2 * OS) @(negedge clk);

      // Break: line low for well over a frame gives exactly one error frame
      parity_i = 2'b00;
      sb.push_back(exp_t'{8'h00, 1'b0, 1'b1});
      rx_i = 1'b0;
      repeat (12 * OS) @(negedge clk);
      chk("break_busy_held_low", busy_o, 1'b0);
      rx_i = 1'b1;
      repeat (3 * OS) @(negedge clk);

      p0 = pulses;
      rx_i = 1'b0;
      repeat (OS / 4) @(negedge clk);
      rx_i = 1'b1;
      repeat (3 * OS) @(negedge clk);
      chk("glitch_busy", busy_o, 1'b0);
      chk("glitch_no_valid", pulses, p0);

      send(8'h01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'hFF, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h80, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2 * OS) @(negedge clk);

      // Abort in the middle of the data bits
      p0 = pulses;
      parity_i = 2'b00;
      bitp(1'b0);
      bitp(1'b1);
      bitp(1'b0);
      bitp(1'b1);
      chk("mid_frame_busy", busy_o, 1'b1);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_data", data_o, 8'h00);
      chk("abort_valid", valid_o, 1'b0);
      chk("abort_perr", parity_err_o, 1'b0);
      chk("abort_ferr", frame_err_o, 1'b0);
      chk("abort_busy", busy_o, 1'b0);
      rx_i = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (12 * OS) @(negedge clk);
      chk("abort_no_valid", pulses, p0);
      chk("abort_idle", busy_o, 1'b0);

      waited = 0;
      while (sb.size() != 0 && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      chk("scoreboard_drained", sb.size(), 0);
      chk("total_pulses", pulses, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
